// File: rtl/pcl_wb_port_arbiter.sv
// pcl_wb_port_arbiter: shares the RF write port between pipeline write-back (priority) and round-robin side requesters.
// Optional starvation guard enabled by defining PCL_WB_ARB_STARVE_GUARD_EN.
module pcl_wb_port_arbiter #(
    parameter int RV64         = 0,
    parameter int NUM_REQ      = 2,
    parameter int STARVE_LIMIT = 8,
    localparam int DW          = 32 * (1 + RV64)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iPipeVld,
    input  logic [4:0]            iPipeRd,
    input  logic [DW-1:0]         iPipeDat,
    input  logic [NUM_REQ-1:0]    iReqVld,
    input  logic [5*NUM_REQ-1:0]  iReqRd,
    input  logic [DW*NUM_REQ-1:0] iReqDat,
    output logic [NUM_REQ-1:0]    oReqRdy,
    output logic                  oPipeStall,
    output logic                  oWbVld,
    output logic [4:0]            oWbRd,
    output logic [DW-1:0]         oWbDat
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ out of range 1..8");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("STARVE_LIMIT out of range 1..255");
    end

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_found;
    logic          w_pipe_occ;
    logic          w_side;
    logic          w_win;
    logic [4:0]    w_win_rd;
    logic [DW-1:0] w_win_dat;

    // first valid requester at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && iReqVld[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_idx   = PW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_pipe_occ = iPipeVld && iPipeRd != 5'd0 && !oPipeStall;
    assign w_side     = rst && w_found && !w_pipe_occ;
    assign oReqRdy    = w_side ? NUM_REQ'(1) << w_idx : '0;
    assign w_win      = w_pipe_occ || w_side;
    assign w_win_rd   = w_pipe_occ ? iPipeRd : iReqRd[5*int'(w_idx) +: 5];
    assign w_win_dat  = w_pipe_occ ? iPipeDat : iReqDat[DW*int'(w_idx) +: DW];
    assign w_ptr_nxt  = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;

    // rd=0 winners still consume the slot but suppress the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr  <= '0;
            oWbVld <= 1'b0;
            oWbRd  <= '0;
            oWbDat <= '0;
        end else begin
            oWbVld <= w_win && w_win_rd != 5'd0;
            if (w_win) begin
                oWbRd  <= w_win_rd;
                oWbDat <= w_win_dat;
            end
            if (w_side)
                r_ptr <= w_ptr_nxt;
        end
    end

`ifdef PCL_WB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_wait [NUM_REQ];
    logic          w_starve;

    always_comb begin
        w_starve = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            w_starve = w_starve || r_wait[i] >= CW'(STARVE_LIMIT);
    end

    assign oPipeStall = w_starve && iPipeVld && iPipeRd != 5'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                r_wait[i] <= (!iReqVld[i] || oReqRdy[i]) ? '0 :
                             (r_wait[i] == CW'(STARVE_LIMIT)) ? r_wait[i] : r_wait[i] + 1'b1;
        end
    end
`else
    assign oPipeStall = 1'b0;
`endif

endmodule

// File: tb/tb_pcl_wb_port_arbiter.sv
// tb_pcl_wb_port_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_pcl_wb_port_arbiter;
    localparam int DW  = 32;
    localparam int NR  = 2;
    localparam int LIM = 8;
`ifdef PCL_WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pvld;
    logic [4:0]       prd;
    logic [DW-1:0]    pdat;
    logic [NR-1:0]    rvld;
    logic [5*NR-1:0]  rrd;
    logic [DW*NR-1:0] rdat;
    logic [NR-1:0]    rdy;
    logic             stall;
    logic             wbvld;
    logic [4:0]       wbrd;
    logic [DW-1:0]    wbdat;

    pcl_wb_port_arbiter #(.RV64(0), .NUM_REQ(NR), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .iPipeVld(pvld), .iPipeRd(prd), .iPipeDat(pdat),
        .iReqVld(rvld), .iReqRd(rrd), .iReqDat(rdat),
        .oReqRdy(rdy), .oPipeStall(stall),
        .oWbVld(wbvld), .oWbRd(wbrd), .oWbDat(wbdat)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int            m_ptr;
    int            m_wait [NR];
    logic          m_vld;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_dat;
    logic [NR-1:0] m_gnt;
    logic [NR-1:0] s_rdy;
    logic          s_stall;

    typedef struct {
        logic          pv;
        logic [4:0]    pr;
        logic [31:0]   pd;
        logic [1:0]    rv;
        logic [4:0]    r0, r1;
        logic [31:0]   d0, d1;
        logic [1:0]    erdy;
        logic          evld;
        logic [4:0]    erd;
        logic [31:0]   edat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_vld = 1'b0;
        m_rd  = '0;
        m_dat = '0;
        m_gnt = '0;
        for (int i = 0; i < NR; i++) m_wait[i] = 0;
    endtask

    // called at posedge+1 with inputs already driven; returns at next posedge+1
    task automatic cycle();
        bit st, pocc, any_starved;
        int win;
        logic [NR-1:0] er;
        any_starved = 1'b0;
        for (int i = 0; i < NR; i++) if (m_wait[i] >= LIM) any_starved = 1'b1;
        st   = GUARD && pvld && prd != 0 && any_starved;
        pocc = pvld && prd != 0 && !st;
        win  = -1;
        if (!pocc)
            for (int k = 0; k < NR; k++)
                if (win < 0 && rvld[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
        er = (win >= 0) ? NR'(1) << win : '0;
        #4;
        s_rdy   = rdy;
        s_stall = stall;
        chk("rdy", rdy, er);
        chk("stall", stall, st);
        if (pocc) begin
            m_vld = 1'b1; m_rd = prd; m_dat = pdat;
        end else if (win >= 0) begin
            m_rd  = rrd[5*win +: 5];
            m_dat = rdat[DW*win +: DW];
            m_vld = m_rd != 0;
            m_ptr = (win + 1) % NR;
        end else begin
            m_vld = 1'b0;
        end
        for (int i = 0; i < NR; i++)
            m_wait[i] = (!rvld[i] || win == i) ? 0 : (m_wait[i] < LIM ? m_wait[i] + 1 : LIM);
        m_gnt = er;
        @(posedge clk); #1;
        chk("wbvld", wbvld, m_vld);
        chk("wbrd", wbrd, m_rd);
        chk("wbdat", wbdat, m_dat);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        tbl[0] = '{1'b0, 5'd0, 32'h00, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB0, 2'b01, 1'b1, 5'd3, 32'hA0};
        tbl[1] = '{1'b1, 5'd5, 32'h11, 2'b11, 5'd3, 5'd4, 32'hA1, 32'hB1, 2'b00, 1'b1, 5'd5, 32'h11};
        tbl[2] = '{1'b0, 5'd0, 32'h00, 2'b11, 5'd3, 5'd4, 32'hA2, 32'hB2, 2'b10, 1'b1, 5'd4, 32'hB2};
        tbl[3] = '{1'b0, 5'd0, 32'h00, 2'b11, 5'd3, 5'd4, 32'hA3, 32'hB3, 2'b01, 1'b1, 5'd3, 32'hA3};
        tbl[4] = '{1'b0, 5'd0, 32'h00, 2'b11, 5'd3, 5'd4, 32'hA4, 32'hB4, 2'b10, 1'b1, 5'd4, 32'hB4};
        tbl[5] = '{1'b1, 5'd0, 32'h33, 2'b10, 5'd3, 5'd4, 32'hA5, 32'hB5, 2'b10, 1'b1, 5'd4, 32'hB5};
        tbl[6] = '{1'b0, 5'd0, 32'h00, 2'b01, 5'd0, 5'd4, 32'hA6, 32'hB6, 2'b01, 1'b0, 5'd0, 32'hA6};
        tbl[7] = '{1'b0, 5'd0, 32'h00, 2'b00, 5'd0, 5'd4, 32'hA7, 32'hB7, 2'b00, 1'b0, 5'd0, 32'hA6};
        tbl[8] = '{1'b1, 5'd0, 32'h44, 2'b00, 5'd0, 5'd4, 32'hA8, 32'hB8, 2'b00, 1'b0, 5'd0, 32'hA6};

        pvld = 1'b1; prd = 5'd5; pdat = 32'h55;
        rvld = 2'b11; rrd = {5'd4, 5'd3}; rdat = {32'hB0, 32'hA0};
        #1 rst = 1'b0;
        #2;
        chk("rst_rdy", rdy, 2'b00);
        chk("rst_stall", stall, 1'b0);
        chk("rst_wbvld", wbvld, 1'b0);
        chk("rst_wbrd", wbrd, 5'd0);
        chk("rst_wbdat", wbdat, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold_wbvld", wbvld, 1'b0);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 9; i++) begin
            pvld = tbl[i].pv; prd = tbl[i].pr; pdat = tbl[i].pd;
            rvld = tbl[i].rv;
            rrd  = {tbl[i].r1, tbl[i].r0};
            rdat = {tbl[i].d1, tbl[i].d0};
            cycle();
            chk($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].erdy);
            chk($sformatf("tbl%0d_wbvld", i), wbvld, tbl[i].evld);
            chk($sformatf("tbl%0d_wbrd", i), wbrd, tbl[i].erd);
            chk($sformatf("tbl%0d_wbdat", i), wbdat, tbl[i].edat);
        end

        pvld = 1'b1; prd = 5'd7; pdat = 32'h77;
        rvld = 2'b01; rrd = {5'd4, 5'd9}; rdat = {32'hB9, 32'h99};
`ifdef PCL_WB_ARB_STARVE_GUARD_EN
        for (int c = 0; c < 12; c++) begin
            cycle();
            chk($sformatf("starve%0d_rdy", c), s_rdy, (c == 8) ? 2'b01 : 2'b00);
            chk($sformatf("starve%0d_stall", c), s_stall, c == 8);
            chk($sformatf("starve%0d_wbrd", c), wbrd, (c == 8) ? 5'd9 : 5'd7);
        end
`else
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk($sformatf("nostarve%0d_rdy", c), s_rdy, 2'b00);
            chk($sformatf("nostarve%0d_stall", c), s_stall, 1'b0);
            chk($sformatf("nostarve%0d_wbrd", c), wbrd, 5'd7);
        end
`endif

        pvld = 1'b0; prd = 5'd0;
        rvld = 2'b00;
        cycle();
        rvld = 2'b01;
        cycle();
        chk("mid_pre_rdy", s_rdy, 2'b01);
        chk("mid_pre_wbvld", wbvld, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_wbvld", wbvld, 1'b0);
        chk("mid_rst_rdy", rdy, 2'b00);
        chk("mid_rst_wbrd", wbrd, 5'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rvld = 2'b11;
        cycle();
        chk("mid_post_rdy", s_rdy, 2'b01);
        chk("mid_post_wbrd", wbrd, 5'd9);

        rvld = 2'b00;
        for (int n = 0; n < 400; n++) begin
            pvld = ($urandom % 4) != 0;
            prd  = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
            pdat = $urandom;
            for (int i = 0; i < NR; i++) begin
                if (!rvld[i] && $urandom % 3 == 0) begin
                    rvld[i] = 1'b1;
                    rrd[5*i +: 5]   = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                    rdat[DW*i +: DW] = $urandom;
                end else if (rvld[i] && $urandom % 20 == 0) begin
                    rvld[i] = 1'b0;
                end
            end
            cycle();
            for (int i = 0; i < NR; i++) if (m_gnt[i]) rvld[i] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
